// File: rtl/alu_div.sv
// alu_div: iterative x86 DIV/IDIV unit, radix-2 restoring, one quotient bit
// per clock. Operand width (8/16/32) is chosen per operation by isize/opsize,
// using the same encoding as the combinational alu.
//
// Optional feature macro: ALU_DIV_SIGNED_EN
//   defined   -> IDIV supported (magnitude/sign handling in PREP, quotient and
//                remainder sign fix-up plus signed range check in FIX)
//   undefined -> signd is ignored, every operation is DIV; latency unchanged
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; the done pulse is presented here
// PREP  | magnitudes, divide-by-zero and quotient-overflow check, load regs
// CALC  | N restoring steps, one quotient bit per cycle
// FIX   | sign fix-up, signed range check, results written with done
// ERR   | divide error found in PREP; reports de with done, no result write

module alu_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        isize,
  input  logic        opsize,
  input  logic        signd,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        de,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ8  = 2'd0,
    SZ16 = 2'd1,
    SZ32 = 2'd2
  } size_t;

  state_t      state_q;
  state_t      state_d;

  // operands latched on accept
  size_t       size_q;
  logic        signd_q;
  logic [63:0] dvd_q;
  logic [31:0] dvs_q;

  // iteration registers
  logic [31:0] rem_q;       // partial remainder, always below the divisor
  logic [31:0] sh_q;        // low dividend half, left-aligned; quotient enters at bit 0
  logic [31:0] dvs_mag_q;
  logic [5:0]  cnt_q;
  logic        qsign_q;
  logic        dsign_q;

  // control strobes from the output process
  logic        accept;
  logic        done_set;
  logic        de_val;
  logic        load_res;

  // size-derived values and PREP combinational results
  size_t       size_in;
  logic [5:0]  n_minus1;
  logic [31:0] mask_n;
  logic [63:0] mask_2n;
  logic        dvd_neg;
  logic        dvs_neg;
  logic        dvd_sign;
  logic        dvs_sign;
  logic [63:0] dvd_m;
  logic [31:0] dvs_m;
  logic [63:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] hi_mag;
  logic [31:0] lo_aln;
  logic        prep_de;

  // CALC step
  logic [32:0] rem_sh;      // the N+1-bit shifted partial remainder
  logic        q_bit;
  logic [31:0] rem_nxt;
  logic [31:0] sh_nxt;

  // FIX results
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_res;
  logic [31:0] r_res;
  logic        fix_de;

  // Size code for the operation being accepted.
  always_comb begin
    size_in = SZ8;
    if (isize) size_in = opsize ? SZ32 : SZ16;
  end

  // Width masks, step count and operand sign bits for the latched size.
  always_comb begin
    n_minus1 = 6'd31;
    mask_n   = 32'hFFFF_FFFF;
    mask_2n  = 64'hFFFF_FFFF_FFFF_FFFF;
    dvd_neg  = dvd_q[63];
    dvs_neg  = dvs_q[31];
    unique case (size_q)
      SZ8: begin
        n_minus1 = 6'd7;
        mask_n   = 32'h0000_00FF;
        mask_2n  = 64'h0000_0000_0000_FFFF;
        dvd_neg  = dvd_q[15];
        dvs_neg  = dvs_q[7];
      end
      SZ16: begin
        n_minus1 = 6'd15;
        mask_n   = 32'h0000_FFFF;
        mask_2n  = 64'h0000_0000_FFFF_FFFF;
        dvd_neg  = dvd_q[31];
        dvs_neg  = dvs_q[15];
      end
      default: ;
    endcase
  end

`ifdef ALU_DIV_SIGNED_EN
  logic [31:0] pos_max;

  // Operand signs only count for IDIV.
  always_comb begin
    dvd_sign = signd_q & dvd_neg;
    dvs_sign = signd_q & dvs_neg;
  end

  // Negate magnitudes back to signed results and apply the IDIV range limits.
  always_comb begin
    pos_max = mask_n >> 1;
    q_res   = qsign_q ? ((~q_mag + 32'd1) & mask_n) : q_mag;
    r_res   = dsign_q ? ((~r_mag + 32'd1) & mask_n) : r_mag;
    fix_de  = 1'b0;
    if (signd_q) begin
      if (qsign_q) fix_de = (q_mag > (pos_max + 32'd1));
      else         fix_de = (q_mag > pos_max);
    end
  end
`else
  logic unused_signed;
  assign unused_signed = ^{signd_q, dvd_neg, dvs_neg, qsign_q, dsign_q};

  // Unsigned-only build: no sign handling at all.
  always_comb begin
    dvd_sign = 1'b0;
    dvs_sign = 1'b0;
  end

  // Unsigned-only build: FIX just truncates.
  always_comb begin
    q_res  = q_mag;
    r_res  = r_mag;
    fix_de = 1'b0;
  end
`endif

  // PREP: operand magnitudes, split into halves, and the #DE pre-checks.
  always_comb begin
    dvd_m   = dvd_q & mask_2n;
    dvs_m   = dvs_q & mask_n;
    dvd_mag = dvd_sign ? ((~dvd_m + 64'd1) & mask_2n) : dvd_m;
    dvs_mag = dvs_sign ? ((~dvs_m + 32'd1) & mask_n) : dvs_m;
    hi_mag  = dvd_mag[63:32];
    lo_aln  = dvd_mag[31:0];
    unique case (size_q)
      SZ8: begin
        hi_mag = {24'd0, dvd_mag[15:8]};
        lo_aln = {dvd_mag[7:0], 24'd0};
      end
      SZ16: begin
        hi_mag = {16'd0, dvd_mag[31:16]};
        lo_aln = {dvd_mag[15:0], 16'd0};
      end
      default: ;
    endcase
    // high half >= divisor means the quotient needs more than N bits
    prep_de = (dvs_mag == 32'd0) || (hi_mag >= dvs_mag);
  end

  // One restoring step; the kept difference is below the divisor so 32 bits hold it.
  always_comb begin
    rem_sh  = {rem_q, sh_q[31]};
    q_bit   = (rem_sh >= {1'b0, dvs_mag_q});
    rem_nxt = q_bit ? (rem_sh[31:0] - dvs_mag_q) : rem_sh[31:0];
    sh_nxt  = {sh_q[30:0], q_bit};
  end

  // Unsigned quotient/remainder magnitudes at the end of CALC.
  always_comb begin
    q_mag = sh_q & mask_n;
    r_mag = rem_q & mask_n;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: state_d = prep_de ? S_ERR : S_CALC;
      S_CALC: if (cnt_q == 6'd0) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: busy level plus the strobes that drive the result registers.
  always_comb begin
    busy     = (state_q != S_IDLE);
    accept   = (state_q == S_IDLE) && start;
    done_set = (state_q == S_FIX) || (state_q == S_ERR);
    de_val   = (state_q == S_ERR) || fix_de;
    load_res = (state_q == S_FIX) && !fix_de;
  end

  // Operand latch, iteration registers and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      size_q    <= SZ8;
      signd_q   <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      sh_q      <= '0;
      dvs_mag_q <= '0;
      cnt_q     <= '0;
      qsign_q   <= 1'b0;
      dsign_q   <= 1'b0;
      done      <= 1'b0;
      de        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= done_set;
      if (done_set) de <= de_val;
      if (load_res) begin
        quotient  <= q_res;
        remainder <= r_res;
      end
      if (accept) begin
        size_q  <= size_in;
        signd_q <= signd;
        dvd_q   <= dividend;
        dvs_q   <= divisor;
      end
      if (state_q == S_PREP) begin
        rem_q     <= hi_mag;
        sh_q      <= lo_aln;
        dvs_mag_q <= dvs_mag;
        qsign_q   <= dvd_sign ^ dvs_sign;
        dsign_q   <= dvd_sign;
        cnt_q     <= n_minus1;
      end
      if (state_q == S_CALC) begin
        rem_q <= rem_nxt;
        sh_q  <= sh_nxt;
        cnt_q <= cnt_q - 6'd1;
      end
    end
  end

endmodule
